// File: rtl/fft_addr_sequencer_pkg.sv
// rtl/fft_addr_sequencer_pkg.sv - shared defaults, FSM state type and width helper for the FFT address sequencer
package fft_addr_sequencer_pkg;

    localparam int LOG2_NFFT_DEF  = 5;
    localparam int DATA_WIDTH_DEF = 16;
    localparam int STAGE_GAP_DEF  = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_GAP  = 2'd2,
        ST_DONE = 2'd3
    } seq_state_t;

    // Stage counter width: enough for 0..L-1 plus one spare bit
    function automatic int stage_width(input int log2_nfft);
        return $clog2(log2_nfft) + 1;
    endfunction

endpackage

// File: rtl/fft_addr_sequencer_if.sv
// rtl/fft_addr_sequencer_if.sv - start/stall handshake and butterfly address bundle of the FFT sequencer
interface fft_addr_sequencer_if #(
    parameter int LOG2_NFFT  = fft_addr_sequencer_pkg::LOG2_NFFT_DEF,
    parameter int DATA_WIDTH = fft_addr_sequencer_pkg::DATA_WIDTH_DEF
);
    import fft_addr_sequencer_pkg::*;

    localparam int STAGE_W = stage_width(LOG2_NFFT);

    logic                  start;
    logic                  stall;
    logic                  busy;
    logic                  valid;
    logic [LOG2_NFFT-1:0]  addr_a;
    logic [LOG2_NFFT-1:0]  addr_b;
    logic [DATA_WIDTH-1:0] tw_addr;
    logic [STAGE_W-1:0]    stage;
    logic                  last_bfly;
    logic                  done;

    // Sequencer side
    modport master (
        input  start, stall,
        output busy, valid, addr_a, addr_b, tw_addr, stage, last_bfly, done
    );

    // Control / datapath side
    modport slave (
        output start, stall,
        input  busy, valid, addr_a, addr_b, tw_addr, stage, last_bfly, done
    );

endinterface

// File: rtl/fft_addr_sequencer_bfly_index.sv
// rtl/fft_addr_sequencer_bfly_index.sv - combinational (stage, butterfly) to operand/twiddle address map
module fft_addr_sequencer_bfly_index
    import fft_addr_sequencer_pkg::*;
#(
    parameter  int LOG2_NFFT  = LOG2_NFFT_DEF,
    parameter  int DATA_WIDTH = DATA_WIDTH_DEF,
    localparam int STAGE_W    = stage_width(LOG2_NFFT),
    localparam int K_W        = LOG2_NFFT - 1
) (
    input  logic [STAGE_W-1:0]    stage,
    input  logic [K_W-1:0]        k,
    output logic [LOG2_NFFT-1:0]  addr_a,
    output logic [LOG2_NFFT-1:0]  addr_b,
    output logic [DATA_WIDTH-1:0] tw_addr,
    output logic                  last
);

    logic [LOG2_NFFT-1:0] k_ext;
    logic [LOG2_NFFT-1:0] h;
    logic [LOG2_NFFT-1:0] p;
    logic [LOG2_NFFT-1:0] j;
    logic [LOG2_NFFT-1:0] tw_p;
    logic [STAGE_W:0]     stage_p1;
    logic [STAGE_W-1:0]   tw_shift;

    // Split k into group j and in-group offset p, then spread groups apart by 2h
    always_comb begin
        k_ext    = {1'b0, k};
        h        = LOG2_NFFT'(1) << stage;
        p        = k_ext & (h - LOG2_NFFT'(1));
        j        = k_ext >> stage;
        stage_p1 = {1'b0, stage} + (STAGE_W + 1)'(1);
        addr_a   = (j << stage_p1) | p;
        addr_b   = addr_a + h;
        tw_shift = STAGE_W'(LOG2_NFFT - 1) - stage;
        tw_p     = p << tw_shift;
        tw_addr  = DATA_WIDTH'(tw_p);
        last     = &k;
    end

endmodule

// File: rtl/fft_addr_sequencer.sv
// rtl/fft_addr_sequencer.sv - radix-2 DIT FFT stage/butterfly sequencer with stall and inter-stage gap
module fft_addr_sequencer
    import fft_addr_sequencer_pkg::*;
#(
    parameter int LOG2_NFFT  = LOG2_NFFT_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int STAGE_GAP  = STAGE_GAP_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    fft_addr_sequencer_if.master  bus
);

    localparam int STAGE_W = stage_width(LOG2_NFFT);
    localparam int K_W     = LOG2_NFFT - 1;
    localparam int GAP_W   = (STAGE_GAP > 1) ? $clog2(STAGE_GAP) : 1;

    localparam logic [STAGE_W-1:0] LAST_STAGE = STAGE_W'(LOG2_NFFT - 1);
    localparam logic [GAP_W-1:0]   LAST_GAP   = GAP_W'((STAGE_GAP > 0) ? STAGE_GAP - 1 : 0);

    seq_state_t            state_q, state_d;
    logic [STAGE_W-1:0]    stage_q, stage_d;
    logic [K_W-1:0]        k_q, k_d;
    logic [GAP_W-1:0]      gap_q, gap_d;
    logic                  valid_q, valid_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  last_q, last_d;
    logic                  load;
    logic [LOG2_NFFT-1:0]  addr_a_q, addr_b_q;
    logic [DATA_WIDTH-1:0] tw_q;
    logic [LOG2_NFFT-1:0]  idx_a, idx_b;
    logic [DATA_WIDTH-1:0] idx_tw;
    logic                  idx_last;

    // Addresses are computed for the butterfly about to be presented, then registered
    fft_addr_sequencer_bfly_index #(
        .LOG2_NFFT  (LOG2_NFFT),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_bfly_index (
        .stage   (stage_d),
        .k       (k_d),
        .addr_a  (idx_a),
        .addr_b  (idx_b),
        .tw_addr (idx_tw),
        .last    (idx_last)
    );

    // Next state, counters and output strobes; stall only freezes the RUN state
    always_comb begin
        state_d = state_q;
        stage_d = stage_q;
        k_d     = k_q;
        gap_d   = gap_q;
        load    = 1'b0;
        valid_d = 1'b0;
        done_d  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d = ST_RUN;
                    stage_d = '0;
                    k_d     = '0;
                    load    = 1'b1;
                    valid_d = 1'b1;
                end
            end
            ST_RUN: begin
                if (bus.stall) begin
                    valid_d = 1'b1;
                end else if (!(&k_q)) begin
                    k_d     = k_q + K_W'(1);
                    load    = 1'b1;
                    valid_d = 1'b1;
                end else if (stage_q == LAST_STAGE) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else if (STAGE_GAP == 0) begin
                    stage_d = stage_q + STAGE_W'(1);
                    k_d     = '0;
                    load    = 1'b1;
                    valid_d = 1'b1;
                end else begin
                    state_d = ST_GAP;
                    gap_d   = '0;
                end
            end
            ST_GAP: begin
                if (gap_q == LAST_GAP) begin
                    state_d = ST_RUN;
                    stage_d = stage_q + STAGE_W'(1);
                    k_d     = '0;
                    load    = 1'b1;
                    valid_d = 1'b1;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
        last_d = valid_d & (load ? idx_last : last_q);
    end

    // FSM state and sequencing counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            stage_q <= '0;
            k_q     <= '0;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            stage_q <= stage_d;
            k_q     <= k_d;
            gap_q   <= gap_d;
        end
    end

    // Output registers; addresses only change when a new butterfly is loaded
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            last_q   <= 1'b0;
            addr_a_q <= '0;
            addr_b_q <= '0;
            tw_q     <= '0;
        end else begin
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            last_q  <= last_d;
            if (load) begin
                addr_a_q <= idx_a;
                addr_b_q <= idx_b;
                tw_q     <= idx_tw;
            end
        end
    end

    assign bus.busy      = busy_q;
    assign bus.valid     = valid_q;
    assign bus.done      = done_q;
    assign bus.last_bfly = last_q;
    assign bus.addr_a    = addr_a_q;
    assign bus.addr_b    = addr_b_q;
    assign bus.tw_addr   = tw_q;
    assign bus.stage     = stage_q;

endmodule

// File: tb/tb_fft_addr_sequencer.sv
// tb/tb_fft_addr_sequencer.sv - scoreboard bench for fft_addr_sequencer (gap 4 and gap 0 instances)
module tb_fft_addr_sequencer;

    localparam int L  = 5;
    localparam int NB = 16;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic stall;
    logic sel;

    fft_addr_sequencer_if #(.LOG2_NFFT(L), .DATA_WIDTH(16)) bus4 ();
    fft_addr_sequencer_if #(.LOG2_NFFT(L), .DATA_WIDTH(16)) bus0 ();

    fft_addr_sequencer #(.LOG2_NFFT(L), .DATA_WIDTH(16), .STAGE_GAP(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus4)
    );

    fft_addr_sequencer #(.LOG2_NFFT(L), .DATA_WIDTH(16), .STAGE_GAP(0)) dut_gap0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    assign bus4.start = start & ~sel;
    assign bus0.start = start & sel;
    assign bus4.stall = stall;
    assign bus0.stall = stall;

    logic        m_busy, m_valid, m_done, m_last;
    logic [4:0]  m_a, m_b;
    logic [15:0] m_tw;
    logic [3:0]  m_stage;

    assign m_busy  = sel ? bus0.busy      : bus4.busy;
    assign m_valid = sel ? bus0.valid     : bus4.valid;
    assign m_done  = sel ? bus0.done      : bus4.done;
    assign m_last  = sel ? bus0.last_bfly : bus4.last_bfly;
    assign m_a     = sel ? bus0.addr_a    : bus4.addr_a;
    assign m_b     = sel ? bus0.addr_b    : bus4.addr_b;
    assign m_tw    = sel ? bus0.tw_addr   : bus4.tw_addr;
    assign m_stage = sel ? bus0.stage     : bus4.stage;

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          edge_n   = 0;
    int          t0       = 0;
    int          gap      = 4;
    int          pat_end  = 0;
    bit          pat_on   = 1'b0;
    bit          mon_on   = 1'b0;
    int          n_valid, n_busy, n_done, done_cyc;
    logic [63:0] sb [$];
    logic [63:0] cap [0:127];
    logic [31:0] cov [0:15];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [63:0] pk(input int s, input int a, input int b, input int tw, input int last);
        return {16'd0, 8'(s), 8'(a), 8'(b), 16'(tw), 8'(last)};
    endfunction

    function automatic logic [63:0] model(input int s, input int k);
        int h  = 1 << s;
        int p  = k & (h - 1);
        int j  = k >> s;
        int a  = (j << (s + 1)) | p;
        return pk(s, a, a + h, p << (L - 1 - s), (k == NB - 1) ? 1 : 0);
    endfunction

    function automatic logic [63:0] exp_ctrl(input int c, input int g);
        int run_end = NB * L + (L - 1) * g;
        bit v = (c >= 1) && (c <= run_end) && (((c - 1) % (NB + g)) < NB);
        bit b = (c >= 1) && (c <= run_end + 1);
        bit d = (c == run_end + 1);
        return {61'd0, b, v, d};
    endfunction

    function automatic logic [63:0] outs_word();
        logic [63:0] w;
        w = pk(int'(m_stage), int'(m_a), int'(m_b), int'(m_tw), int'(m_last));
        w[63:61] = {m_busy, m_valid, m_done};
        return w;
    endfunction

    initial forever begin
        @(posedge clk);
        edge_n++;
    end

    // Monitor: per-cycle control pattern, scoreboard compare, captures and coverage
    initial forever begin
        @(negedge clk);
        if (mon_on && !rst) begin
            int c;
            logic [63:0] obs;
            c = edge_n - t0 + 1;
            obs = pk(int'(m_stage), int'(m_a), int'(m_b), int'(m_tw), int'(m_last));
            if (m_busy) n_busy++;
            if (m_done) begin
                n_done++;
                done_cyc = c;
            end
            if (pat_on && c >= 0 && c <= pat_end)
                check($sformatf("ctrl_c%0d", c), {61'd0, m_busy, m_valid, m_done}, exp_ctrl(c, gap));
            if (m_valid) begin
                n_valid++;
                if (c >= 0 && c < 128) cap[c] = obs;
                cov[m_stage] = cov[m_stage] | (32'd1 << m_a) | (32'd1 << m_b);
                if (sb.size() == 0) begin
                    check("sb_underflow", 64'(sb.size()), 64'd1);
                end else begin
                    check($sformatf("bfly_c%0d", c), obs, sb[0]);
                    if (!stall) void'(sb.pop_front());
                end
            end
        end
    end

    task automatic start_run(input int gap_v, input bit pat);
        @(posedge clk);
        #1;
        sb.delete();
        for (int s = 0; s < L; s++)
            for (int k = 0; k < NB; k++)
                sb.push_back(model(s, k));
        for (int i = 0; i < 128; i++) cap[i] = '0;
        for (int i = 0; i < 16; i++) cov[i] = '0;
        n_valid  = 0;
        n_busy   = 0;
        n_done   = 0;
        done_cyc = -1;
        gap      = gap_v;
        pat_on   = pat;
        pat_end  = NB * L + (L - 1) * gap_v + 11;
        t0       = edge_n + 1;
        mon_on   = 1'b1;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
    endtask

    task automatic wait_cyc(input int c);
        for (int i = 0; i < 2000 && (edge_n - t0 + 1) < c; i++) begin
            @(posedge clk);
            #1;
        end
        if ((edge_n - t0 + 1) < c)
            check("wait_bound", 64'(edge_n - t0 + 1), 64'(c));
    endtask

    task automatic pulse_start_at(input int c);
        wait_cyc(c);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        stall = 1'b0;
        sel   = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        check("reset_outs", outs_word(), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("idle_after_reset", outs_word(), 64'd0);

        // Plain run, gap 4
        start_run(4, 1'b1);
        wait_cyc(109);
        check("t1_done_cyc", 64'(done_cyc), 64'd97);
        check("t1_done_cnt", 64'(n_done), 64'd1);
        check("t1_valid_cnt", 64'(n_valid), 64'd80);
        check("t1_busy_cnt", 64'(n_busy), 64'd97);
        check("t1_sb_left", 64'(sb.size()), 64'd0);
        check("spot_s0k0", cap[1], pk(0, 0, 1, 0, 0));
        check("spot_s0k1", cap[2], pk(0, 2, 3, 0, 0));
        check("spot_s2k5", cap[46], pk(2, 9, 13, 4, 0));
        check("spot_s4k15", cap[96], pk(4, 15, 31, 15, 1));
        for (int s = 0; s < L; s++)
            check($sformatf("t1_cov_s%0d", s), 64'(cov[s]), 64'hFFFF_FFFF);

        // Stall 3 cycles at s=1,k=7
        start_run(4, 1'b0);
        wait_cyc(28);
        stall = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        stall = 1'b0;
        wait_cyc(112);
        check("t3_done_cyc", 64'(done_cyc), 64'd100);
        check("t3_done_cnt", 64'(n_done), 64'd1);
        check("t3_valid_cnt", 64'(n_valid), 64'd83);
        check("t3_busy_cnt", 64'(n_busy), 64'd100);
        check("t3_sb_left", 64'(sb.size()), 64'd0);
        for (int c = 28; c < 32; c++)
            check($sformatf("t3_hold_c%0d", c), cap[c], pk(1, 13, 15, 8, 0));
        check("t3_after_stall", cap[32], pk(1, 16, 18, 0, 0));

        // Extra Start pulses during Busy and on the Done cycle
        start_run(4, 1'b1);
        pulse_start_at(30);
        pulse_start_at(97);
        wait_cyc(109);
        check("t5_done_cnt", 64'(n_done), 64'd1);
        check("t5_done_cyc", 64'(done_cyc), 64'd97);
        check("t5_valid_cnt", 64'(n_valid), 64'd80);

        // Reset mid-run, then restart
        start_run(4, 1'b1);
        wait_cyc(50);
        pat_on = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("t4_rst_async", outs_word(), 64'd0);
        sb.delete();
        n_done = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("t4_abort_no_done", 64'(n_done), 64'd0);
        check("t4_abort_idle", outs_word(), 64'd0);
        start_run(4, 1'b1);
        wait_cyc(109);
        check("t4_restart_first", cap[1], pk(0, 0, 1, 0, 0));
        check("t4_done_cyc", 64'(done_cyc), 64'd97);
        check("t4_sb_left", 64'(sb.size()), 64'd0);

        // Gap 0 instance
        sel = 1'b1;
        start_run(0, 1'b1);
        wait_cyc(92);
        check("t6_done_cyc", 64'(done_cyc), 64'd81);
        check("t6_valid_cnt", 64'(n_valid), 64'd80);
        check("t6_busy_cnt", 64'(n_busy), 64'd81);
        check("t6_sb_left", 64'(sb.size()), 64'd0);
        for (int s = 0; s < L; s++)
            check($sformatf("t6_cov_s%0d", s), 64'(cov[s]), 64'hFFFF_FFFF);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
